// File: rtl/snn_ctrl_pkg.sv
// Shared control definitions for the SNN core: scheduler FSM encoding and
// default core geometry.
package snn_ctrl_pkg;

   localparam int N_NEUR_DEF           = 256;
   localparam int ADDR_WIDTH_DEF       = 8;
   localparam int SYN_WEIGHT_WIDTH_DEF = 4;
   localparam int LEAK_LAT_DEF         = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EV_RD,
      S_EV_EXEC,
      S_EV_WB,
      S_LK_RD,
      S_LK_EXEC,
      S_LK_WB
   } state_t;

   function automatic logic is_leak_state(input state_t s);
      return (s == S_LK_RD) || (s == S_LK_EXEC) || (s == S_LK_WB);
   endfunction

endpackage

// File: rtl/neuron_update_scheduler_if.sv
// Synaptic event handshake bundle between the event router (master) and the
// neuron update scheduler (slave).
interface neuron_update_scheduler_if #(
   parameter int ADDR_WIDTH       = 8,
   parameter int SYN_WEIGHT_WIDTH = 4
);
   logic                        ev_valid;
   logic                        ev_ready;
   logic [ADDR_WIDTH-1:0]       ev_addr;
   logic                        ev_inh;
   logic [SYN_WEIGHT_WIDTH-1:0] ev_weight;

   modport master (
      output ev_valid, ev_addr, ev_inh, ev_weight,
      input  ev_ready
   );

   modport slave (
      input  ev_valid, ev_addr, ev_inh, ev_weight,
      output ev_ready
   );
endinterface

// File: rtl/neuron_update_scheduler.sv
// Sequences state-SRAM read / datapath execute / write-back for synaptic events
// and for periodic full-core leak sweeps; leak requests take priority.
module neuron_update_scheduler
   import snn_ctrl_pkg::*;
#(
   parameter int N_NEUR           = N_NEUR_DEF,
   parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
   parameter int SYN_WEIGHT_WIDTH = SYN_WEIGHT_WIDTH_DEF,
   parameter int LEAK_LAT         = LEAK_LAT_DEF
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        leak_tick,
   neuron_update_scheduler_if.slave    ev,
   output logic                        sram_rd_en,
   output logic [ADDR_WIDTH-1:0]       sram_rd_addr,
   output logic                        sram_wr_en,
   output logic [ADDR_WIDTH-1:0]       sram_wr_addr,
   output logic                        dp_event_leak,
   output logic                        dp_event_exc,
   output logic                        dp_event_inh,
   output logic [SYN_WEIGHT_WIDTH-1:0] dp_syn_weight,
   input  logic                        dp_spike,
   output logic                        spike_valid,
   output logic [ADDR_WIDTH-1:0]       spike_addr,
   output logic                        busy,
   output logic                        sweep_done,
   output logic                        leak_overrun
);

   localparam int LAT_W = (LEAK_LAT > 1) ? $clog2(LEAK_LAT) : 1;

   state_t                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d;
   logic [LAT_W-1:0]            lat_q, lat_d;
   logic                        pend_q, pend_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic                        inh_q, inh_d;
   logic [SYN_WEIGHT_WIDTH-1:0] wgt_q, wgt_d;
   logic                        in_leak;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lat_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         pend_q  <= pend_d;
      end
   end

   // Captured event fields are only consumed in EV_* states, so no reset needed.
   always_ff @(posedge CLK) begin
      addr_q <= addr_d;
      inh_q  <= inh_d;
      wgt_q  <= wgt_d;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      lat_d         = lat_q;
      pend_d        = pend_q;
      addr_d        = addr_q;
      inh_d         = inh_q;
      wgt_d         = wgt_q;
      ev.ev_ready   = 1'b0;
      sram_rd_en    = 1'b0;
      sram_rd_addr  = '0;
      sram_wr_en    = 1'b0;
      sram_wr_addr  = '0;
      dp_event_leak = 1'b0;
      dp_event_exc  = 1'b0;
      dp_event_inh  = 1'b0;
      dp_syn_weight = '0;
      spike_valid   = 1'b0;
      spike_addr    = '0;
      sweep_done    = 1'b0;

      in_leak      = is_leak_state(state_q);
      busy         = (state_q != S_IDLE);
      leak_overrun = leak_tick & (pend_q | in_leak) & ~RST;
      if (leak_tick && !pend_q && !in_leak)
         pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (pend_q || leak_tick) begin
               state_d = S_LK_RD;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else begin
               ev.ev_ready = ~RST;
               if (ev.ev_valid) begin
                  addr_d  = ev.ev_addr;
                  inh_d   = ev.ev_inh;
                  wgt_d   = ev.ev_weight;
                  state_d = S_EV_RD;
               end
            end
         end
         S_EV_RD: begin
            sram_rd_en   = 1'b1;
            sram_rd_addr = addr_q;
            state_d      = S_EV_EXEC;
         end
         S_EV_EXEC: begin
            dp_event_exc  = ~inh_q;
            dp_event_inh  = inh_q;
            dp_syn_weight = wgt_q;
            state_d       = S_EV_WB;
         end
         S_EV_WB: begin
            sram_wr_en   = 1'b1;
            sram_wr_addr = addr_q;
            spike_valid  = dp_spike;
            spike_addr   = addr_q;
            state_d      = S_IDLE;
         end
         S_LK_RD: begin
            sram_rd_en   = 1'b1;
            sram_rd_addr = cnt_q;
            lat_d        = LAT_W'(LEAK_LAT - 1);
            state_d      = S_LK_EXEC;
         end
         S_LK_EXEC: begin
            dp_event_leak = 1'b1;
            if (lat_q == '0)
               state_d = S_LK_WB;
            else
               lat_d = lat_q - 1'b1;
         end
         S_LK_WB: begin
            sram_wr_en   = 1'b1;
            sram_wr_addr = cnt_q;
            spike_valid  = dp_spike;
            spike_addr   = cnt_q;
            if (cnt_q == ADDR_WIDTH'(N_NEUR - 1)) begin
               sweep_done = 1'b1;
               cnt_d      = '0;
               state_d    = S_IDLE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = S_LK_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Directed bench for neuron_update_scheduler (N_NEUR=8, LEAK_LAT=3): event
// table, leak sweep with priority/overrun/spike, pending leak and mid-sweep reset.
module tb_neuron_update_scheduler;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int WW = 4;
   localparam int LL = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          leak_tick;
   logic          sram_rd_en, sram_wr_en;
   logic [AW-1:0] sram_rd_addr, sram_wr_addr, spike_addr;
   logic          dp_event_leak, dp_event_exc, dp_event_inh;
   logic [WW-1:0] dp_syn_weight;
   logic          dp_spike, spike_valid, busy, sweep_done, leak_overrun;

   neuron_update_scheduler_if #(.ADDR_WIDTH(AW), .SYN_WEIGHT_WIDTH(WW)) ev_if ();

   neuron_update_scheduler #(
      .N_NEUR(N), .ADDR_WIDTH(AW), .SYN_WEIGHT_WIDTH(WW), .LEAK_LAT(LL)
   ) dut (
      .CLK(CLK), .RST(RST), .leak_tick(leak_tick), .ev(ev_if.slave),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
      .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
      .dp_event_leak(dp_event_leak), .dp_event_exc(dp_event_exc),
      .dp_event_inh(dp_event_inh), .dp_syn_weight(dp_syn_weight),
      .dp_spike(dp_spike), .spike_valid(spike_valid), .spike_addr(spike_addr),
      .busy(busy), .sweep_done(sweep_done), .leak_overrun(leak_overrun)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic          lt, ev;
      logic [AW-1:0] a;
      logic          inh;
      logic [WW-1:0] w;
      logic          sp;
      logic          busy, rdy, rd, wr, lk, ex, ih, sv, sd, ov;
      logic [AW-1:0] ea;
      logic [WW-1:0] ew;
   } vec_t;

   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(input logic lt, ev, input logic [AW-1:0] a,
                               input logic inh, input logic [WW-1:0] w, input logic sp,
                               input logic bsy, rdy, rd, wr, lk, ex, ih, sv, sd, ov,
                               input logic [AW-1:0] ea, input logic [WW-1:0] ew);
      vec_t v;
      v.lt = lt; v.ev = ev; v.a = a; v.inh = inh; v.w = w; v.sp = sp;
      v.busy = bsy; v.rdy = rdy; v.rd = rd; v.wr = wr; v.lk = lk;
      v.ex = ex; v.ih = ih; v.sv = sv; v.sd = sd; v.ov = ov; v.ea = ea; v.ew = ew;
      return v;
   endfunction

   function automatic logic [22:0] pk(input logic bsy, rdy, rd, input logic [AW-1:0] rda,
                                      input logic wr, input logic [AW-1:0] wra,
                                      input logic lk, ex, ih, input logic [WW-1:0] w,
                                      input logic sv, input logic [AW-1:0] sa,
                                      input logic sd, ov);
      return {bsy, rdy, rd, rda, wr, wra, lk, ex, ih, w, sv, sa, sd, ov};
   endfunction

   function automatic logic [22:0] exp_of(input vec_t v);
      return pk(v.busy, v.rdy, v.rd, v.rd ? v.ea : '0, v.wr, v.wr ? v.ea : '0,
                v.lk, v.ex, v.ih, v.ew, v.sv, v.wr ? v.ea : '0, v.sd, v.ov);
   endfunction

   task automatic chk(input string nm, input logic [22:0] exp);
      logic [22:0] act;
      act = pk(busy, ev_if.ev_ready, sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr,
               dp_event_leak, dp_event_exc, dp_event_inh, dp_syn_weight,
               spike_valid, spike_addr, sweep_done, leak_overrun);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: outputs got %06h expected %06h", nm, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input string nm);
      @(posedge CLK);
      #2;
      leak_tick       = v.lt;
      ev_if.ev_valid  = v.ev;
      ev_if.ev_addr   = v.a;
      ev_if.ev_inh    = v.inh;
      ev_if.ev_weight = v.w;
      dp_spike        = v.sp;
      #1;
      chk(nm, exp_of(v));
   endtask

   vec_t tbl [10];

   initial begin
      //        lt ev a  inh w  sp  bsy rdy rd wr lk ex ih sv sd ov ea ew
      tbl[0] = mk(0, 1, 5, 0, 3, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 0);
      tbl[2] = mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3);
      tbl[3] = mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 5, 0);
      tbl[4] = mk(0, 1, 6, 1, 9, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[5] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6, 0);
      tbl[6] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 9);
      tbl[7] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6, 0);
      tbl[8] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[9] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      RST = 1'b1; leak_tick = 1'b0; dp_spike = 1'b0;
      ev_if.ev_valid = 1'b0; ev_if.ev_addr = '0; ev_if.ev_inh = 1'b0; ev_if.ev_weight = '0;
      #3 chk("reset_outputs", '0);
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
      #1 chk("idle_after_reset", pk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));

      for (int i = 0; i < 10; i++)
         step(tbl[i], $sformatf("event_vec%0d", i));

      // leak_tick and ev_valid together: leak wins, event waits for the sweep
      step(mk(1,1,1,0,2,0, 0,0,0,0,0,0,0,0,0,0,0,0), "sweep_start_ready_low");
      for (int k = 0; k < N * (LL + 2); k++) begin
         int n, ph;
         n  = k / (LL + 2);
         ph = k % (LL + 2);
         step(mk((k == 10), 1, 1, 0, 2, (ph == 4 && n == 2) || (ph == 2),
                 1, 0, (ph == 0), (ph == 4), (ph >= 1 && ph <= 3), 0, 0,
                 (ph == 4 && n == 2), (k == N * (LL + 2) - 1), (k == 10),
                 AW'(n), 0), $sformatf("sweep_k%0d", k));
      end
      step(mk(0,1,1,0,2,0, 0,1,0,0,0,0,0,0,0,0,0,0), "post_sweep_accept");
      step(mk(0,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,1,0), "post_sweep_ev_rd");
      step(mk(0,0,0,0,0,0, 1,0,0,0,0,1,0,0,0,0,0,2), "post_sweep_ev_exec");
      step(mk(0,0,0,0,0,0, 1,0,0,1,0,0,0,0,0,0,1,0), "post_sweep_ev_wb");
      step(mk(0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0,0,0), "no_second_sweep_a");
      step(mk(0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0,0,0), "no_second_sweep_b");

      // leak requested during an event is deferred; a second request overruns
      step(mk(0,1,3,0,1,0, 0,1,0,0,0,0,0,0,0,0,0,0), "pend_accept");
      step(mk(1,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,3,0), "pend_tick_ev_rd");
      step(mk(1,0,0,0,0,0, 1,0,0,0,0,1,0,0,0,1,0,1), "pend_overrun");
      step(mk(0,0,0,0,0,0, 1,0,0,1,0,0,0,0,0,0,3,0), "pend_ev_wb");
      step(mk(0,1,4,0,1,0, 0,0,0,0,0,0,0,0,0,0,0,0), "pend_idle_not_ready");
      step(mk(0,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,0,0), "pend_lk_rd0");
      for (int c = 0; c < LL; c++)
         step(mk(0,0,0,0,0,0, 1,0,0,0,1,0,0,0,0,0,0,0), $sformatf("pend_lk_exec0_%0d", c));
      step(mk(0,0,0,0,0,0, 1,0,0,1,0,0,0,0,0,0,0,0), "pend_lk_wb0");
      step(mk(0,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,1,0), "pend_lk_rd1");
      step(mk(0,0,0,0,0,0, 1,0,0,0,1,0,0,0,0,0,0,0), "pend_lk_exec1");

      // asynchronous reset in the middle of LK_EXEC of neuron 1
      @(posedge CLK);
      #2 RST = 1'b1;
      #1 chk("rst_mid_exec_immediate", '0);
      @(posedge CLK);
      #1 chk("rst_held_no_wb", '0);
      #1 RST = 1'b0;
      #1 chk("rst_release_idle", pk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
      step(mk(0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0,0,0), "rst_no_resume");
      step(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0), "rst_new_tick");
      step(mk(0,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0,0,0), "rst_sweep_restarts_at0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_update_scheduler.md
NEURON_UPDATE_SCHEDULER -- requirements
Module: neuron_update_scheduler

Interface
REQ-001 SHALL have parameter N_NEUR, default 256, neurons per core (power of two).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, equal to log2(N_NEUR).
REQ-003 SHALL have parameter SYN_WEIGHT_WIDTH, default 4, synaptic weight width.
REQ-004 SHALL have parameter LEAK_LAT, default 3, number of cycles dp_event_leak must be held for one neuron update.
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port RST  input  1  asynchronous reset, active-high.
REQ-007 SHALL have port leak_tick  input  1  one-cycle pulse requesting a full leak sweep.
REQ-008 SHALL have ports ev_valid/ev_ready  input/output  1/1  synaptic event handshake.
REQ-009 SHALL have ports ev_addr, ev_inh, ev_weight  input  ADDR_WIDTH/1/SYN_WEIGHT_WIDTH  target neuron, inhibitory flag, weight.
REQ-010 SHALL have ports sram_rd_en, sram_rd_addr  output  1/ADDR_WIDTH  state-SRAM read; data valid to datapath one cycle later.
REQ-011 SHALL have ports sram_wr_en, sram_wr_addr  output  1/ADDR_WIDTH  state-SRAM write-back of datapath next-state.
REQ-012 SHALL have ports dp_event_leak, dp_event_exc, dp_event_inh, dp_syn_weight  output  1/1/1/SYN_WEIGHT_WIDTH  datapath controls.
REQ-013 SHALL have port dp_spike  input  1  datapath spike bit, valid in the write-back cycle.
REQ-014 SHALL have ports spike_valid, spike_addr  output  1/ADDR_WIDTH  one-cycle spike report.
REQ-015 SHALL have ports busy, sweep_done, leak_overrun  output  1/1/1  status; sweep_done, leak_overrun one-cycle pulses.

Function
REQ-016 SHALL implement FSM states IDLE, EV_RD, EV_EXEC, EV_WB, LK_RD, LK_EXEC, LK_WB.
REQ-017 SHALL latch leak_tick into leak_pending in any state; leak_tick while leak_pending=1 or during LK_* SHALL pulse leak_overrun and be dropped.
REQ-018 IDLE: leak_pending=1 -> LK_RD with neuron counter=0, clear leak_pending; else ev_ready=1, and ev_valid&ev_ready -> EV_RD, capturing ev_addr/ev_inh/ev_weight.
REQ-019 ev_ready SHALL be 1 only in IDLE with leak_pending=0 and no leak_tick in that cycle (leak has priority).
REQ-020 EV_RD (1 cycle): sram_rd_en=1, sram_rd_addr=captured addr -> EV_EXEC.
REQ-021 EV_EXEC (1 cycle): dp_event_exc=~inh, dp_event_inh=inh, dp_syn_weight=captured weight -> EV_WB.
REQ-022 EV_WB (1 cycle): sram_wr_en=1, sram_wr_addr=captured addr; spike_valid=dp_spike, spike_addr=addr -> IDLE.
REQ-023 LK_RD (1 cycle): sram_rd_en=1, sram_rd_addr=counter -> LK_EXEC.
REQ-024 LK_EXEC: dp_event_leak=1 for exactly LEAK_LAT consecutive cycles (internal down-counter) -> LK_WB.
REQ-025 LK_WB (1 cycle): write-back at counter, spike report as REQ-022; counter=N_NEUR-1 -> sweep_done pulse, IDLE; else counter+1 -> LK_RD.
REQ-026 Per-neuron cost SHALL be 3 cycles (event) and LEAK_LAT+2 cycles (leak); full sweep N_NEUR*(LEAK_LAT+2) cycles.
REQ-027 At most one of dp_event_leak/exc/inh SHALL be high in any cycle; all datapath and SRAM controls 0 in IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Counter SHALL not wrap; sweep always starts at 0 and ends at N_NEUR-1.

Reset
REQ-030 RST=1 SHALL immediately force IDLE, counter=0, leak_pending=0 and all outputs to 0; an interrupted sweep or event is abandoned, no write-back issued.

Structure
REQ-031 SHALL take FSM state encoding and ADDR_WIDTH/LEAK_LAT defaults from shared package snn_ctrl_pkg.
REQ-032 SHALL be a single module; no sub-modules.

Verification
REQ-033 Exc event addr 5, weight 3 from IDLE -> rd_en@+1 addr 5, dp_event_exc@+2 weight 3, wr_en@+3 addr 5, ready again @+4.
REQ-034 leak_tick, N_NEUR=4, LEAK_LAT=3 -> dp_event_leak high 3 cycles per neuron, writes to 0,1,2,3, sweep_done 20 cycles after start.
REQ-035 leak_tick and ev_valid same cycle in IDLE -> ev_ready=0, sweep runs first, event accepted in IDLE after sweep_done.
REQ-036 dp_spike=1 in LK_WB of neuron 2 -> spike_valid one cycle with spike_addr=2.
REQ-037 leak_tick during sweep -> leak_overrun pulse, no second sweep.
REQ-038 RST asserted mid-LK_EXEC -> outputs 0 same cycle, no sram_wr_en, next leak sweep starts at address 0.
